// File: rtl/staged_halfsum_pipe_if.sv
// Stream bundle for staged_halfsum_pipe: input stream, output stream, hit counter.
// slave is the pipe's view of the bundle, master is the producer/consumer view.
interface staged_halfsum_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      hit_count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output hit_count
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  hit_count
    );
endinterface

// File: rtl/staged_halfsum_pipe.sv
// Three-stage half-sum classifier with a global stall; emits {TAG, result}.
// Define STAGING_HIT_COUNT_EN to build the saturating SUM-result counter.
module staged_halfsum_pipe #(
    parameter int          WIDTH     = 32,
    parameter int unsigned THRESHOLD = 100,
    parameter int unsigned MATCH_HI  = 1,
    parameter int unsigned TAG       = 2748
) (
    input  logic                 clk,
    input  logic                 reset,
    staged_halfsum_pipe_if.slave bus
);
    localparam int H = WIDTH / 2;

    localparam logic [WIDTH-1:0] THR   = WIDTH'(THRESHOLD);
    localparam logic [H-1:0]     MATCH = H'(MATCH_HI);
    localparam logic [H-1:0]     TAGH  = H'(TAG);

    logic advance;

    logic v1;
    logic v2;
    logic v3;

    logic [WIDTH-1:0] d1;
    logic             above1;
    logic             match1;
    logic             sum1;

    logic             cls2;
    logic [H-1:0]     a2;
    logic [H-1:0]     b2;
    logic [H-1:0]     res2;

    logic [WIDTH-1:0] out_q;

    // One stall signal for every stage keeps bubbles in place while blocked.
    assign advance = !v3 || bus.out_ready;
    assign sum1    = above1 && match1;
    assign res2    = a2 + b2;

    assign bus.in_ready  = advance;
    assign bus.out_valid = v3;
    assign bus.out_data  = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (advance) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (advance) begin
            out_q <= {TAGH, res2};
        end
    end

    // Operand registers need no reset; their valid bits gate them.
    always_ff @(posedge clk) begin
        if (advance) begin
            d1     <= bus.in_data;
            above1 <= bus.in_data > THR;
            match1 <= bus.in_data[WIDTH-1:H] == MATCH;
            cls2   <= sum1;
            a2     <= sum1 ? d1[WIDTH-1:H] : H'(1);
            b2     <= sum1 ? d1[H-1:0] : '0;
        end
    end

`ifdef STAGING_HIT_COUNT_EN
    logic        cls3;
    logic [15:0] hits;

    always_ff @(posedge clk) begin
        if (advance) begin
            cls3 <= cls2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits <= '0;
        end else if (v3 && bus.out_ready && cls3 && hits != 16'hFFFF) begin
            hits <= hits + 16'd1;
        end
    end

    assign bus.hit_count = hits;
`else
    logic unused_cls;

    assign unused_cls    = cls2;
    assign bus.hit_count = '0;
`endif

endmodule

// File: tb/tb_staged_halfsum_pipe.sv
// Directed bench for staged_halfsum_pipe: vector table, stall burst, async reset.
// Expected hit counts follow STAGING_HIT_COUNT_EN as seen by the bench.
module tb_staged_halfsum_pipe;
    logic clk;
    logic reset;

    staged_halfsum_pipe_if #(.WIDTH(32)) bus ();

    staged_halfsum_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef STAGING_HIT_COUNT_EN
    localparam bit HC_EN = 1'b1;
`else
    localparam bit HC_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        bit          sum;
    } vec_t;

    vec_t tv[8];

    int   errors;
    int   checks;
    int   hits_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sends one word alone with out_ready high and tracks its path.
    task automatic send_one(input int idx);
        int k;
        k = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = tv[idx].din;
        #1;
        chk($sformatf("in_ready[%0d]", idx), 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                k = i;
                break;
            end
        end
        chk($sformatf("latency[%0d]", idx), 32'(k), 32'd2);
        chk($sformatf("out_data[%0d]", idx), bus.out_data, tv[idx].dout);
        if (HC_EN && tv[idx].sum)
            hits_m++;
        @(negedge clk);
        chk($sformatf("pulse[%0d]", idx), 32'(bus.out_valid), 32'd0);
        chk($sformatf("hit_count[%0d]", idx), 32'(bus.hit_count), 32'(hits_m));
    endtask

    initial begin
        int          sel[5];
        logic [31:0] sw_in[5];
        logic [31:0] sw_out[5];
        bit          sw_sum[5];
        int          sent;
        int          recv;
        int          first_cyc;
        int          last_cyc;
        bit          acc;

        tv[0] = '{32'h0001_0010, 32'h0ABC_0011, 1'b1};
        tv[1] = '{32'h0002_0010, 32'h0ABC_0001, 1'b0};
        tv[2] = '{32'h0000_0064, 32'h0ABC_0001, 1'b0};
        tv[3] = '{32'h0000_0065, 32'h0ABC_0001, 1'b0};
        tv[4] = '{32'h0001_FFFF, 32'h0ABC_0000, 1'b1};
        tv[5] = '{32'h0001_0000, 32'h0ABC_0001, 1'b1};
        tv[6] = '{32'h0001_1234, 32'h0ABC_1235, 1'b1};
        tv[7] = '{32'hFFFF_FFFF, 32'h0ABC_0001, 1'b0};

        errors = 0;
        checks = 0;
        hits_m = 0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // The latency loop counts negedges after the one that drops in_valid,
        // so a 3-edge latency shows up as k == 2.
        for (int i = 0; i < 8; i++)
            send_one(i);

        sel = '{0, 1, 4, 6, 7};
        for (int i = 0; i < 5; i++) begin
            sw_in[i]  = tv[sel[i]].din;
            sw_out[i] = tv[sel[i]].dout;
            sw_sum[i] = tv[sel[i]].sum;
        end
        sent      = 0;
        recv      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 30 && recv < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 6)
                chk("stall_accepted", 32'(sent), 32'd3);
            bus.out_ready = (cyc >= 6);
            bus.in_valid  = (sent < 5);
            bus.in_data   = (sent < 5) ? sw_in[sent] : 32'd0;
            #1;
            if (cyc == 5)
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && !bus.out_ready)
                chk($sformatf("stall_hold[%0d]", cyc), bus.out_data, sw_out[recv]);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stall_order[%0d]", recv), bus.out_data, sw_out[recv]);
                if (HC_EN && sw_sum[recv])
                    hits_m++;
                if (first_cyc < 0)
                    first_cyc = cyc;
                last_cyc = cyc;
                recv++;
            end
            @(posedge clk);
            if (acc)
                sent++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall_recv", 32'(recv), 32'd5);
        chk("stall_rate", 32'(last_cyc - first_cyc), 32'd4);
        @(negedge clk);
        chk("stall_hits", 32'(bus.hit_count), 32'(hits_m));

        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = tv[0].din;
        @(negedge clk);
        bus.in_data   = tv[6].din;
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        hits_m       = 0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", bus.out_data, 32'd0);
        chk("arst_hit_count", 32'(bus.hit_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("arst_flushed[%0d]", i), 32'(bus.out_valid), 32'd0);
        end
        send_one(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
